// File: rtl/slow_clk_pkg.sv
// Shared types and default constants for the slow clock monitor.
// Optional jitter checking is enabled with SLOW_CLK_JITTER_CHECK_EN.
package slow_clk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOCKED,
        STALL
    } mon_state_t;

    localparam int          DEF_SYNC_STAGES = 2;
    localparam int          DEF_CNT_W       = 32;
    localparam int unsigned DEF_TIMEOUT     = 12_000_000;
    localparam int          DEF_JITTER_TOL  = 2;

endpackage

// File: rtl/slow_clk_monitor_if.sv
// Bundle between a divided-clock source, the monitor and its consumers.
// jitter_err reads 0 unless SLOW_CLK_JITTER_CHECK_EN is defined.
interface slow_clk_monitor_if
    import slow_clk_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             slow_clk;
    logic             tick_rise;
    logic             tick_fall;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             stalled;
    logic [15:0]      edge_count;
    logic             jitter_err;

    modport master (
        input  slow_clk,
        output tick_rise,
        output tick_fall,
        output half_period,
        output period_valid,
        output stalled,
        output edge_count,
        output jitter_err
    );

    modport slave (
        output slow_clk,
        input  tick_rise,
        input  tick_fall,
        input  half_period,
        input  period_valid,
        input  stalled,
        input  edge_count,
        input  jitter_err
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level plus a previous-sample
// flop; rise/fall are combinational one-cycle strobes in the clk domain.
module sync_edge_detect
    import slow_clk_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_i,
    output logic sync_level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], d_i};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_level_o = sync_q[SYNC_STAGES-1];
    assign rise_o       = sync_level_o & ~prev_q;
    assign fall_o       = ~sync_level_o & prev_q;

endmodule

// File: rtl/slow_clk_monitor.sv
// Turns a divided clock into rise/fall enables, measures its half-period
// and flags a stalled source. SLOW_CLK_JITTER_CHECK_EN adds jitter_err.
module slow_clk_monitor
    import slow_clk_pkg::*;
#(
    parameter int          SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
`ifdef SLOW_CLK_JITTER_CHECK_EN
    ,
    parameter int          JITTER_TOL  = DEF_JITTER_TOL
`endif
) (
    input logic                clk,
    input logic                n_rst,
    slow_clk_monitor_if.master mon
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic sync_level;
    logic rise;
    logic fall;
    logic edge_w;
    logic timeout;
    logic cap;

    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic [CNT_W-1:0] meas;
    logic             pv_q, pv_d;
    logic             st_q, st_d;
    logic             tr_q, tf_q;
    logic [15:0]      ec_q, ec_d;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_i          (mon.slow_clk),
        .sync_level_o (sync_level),
        .rise_o       (rise),
        .fall_o       (fall)
    );

    edge_level_a: assert property (@(posedge clk) disable iff (!n_rst)
        !(rise && !sync_level) && !(fall && sync_level));

    assign edge_w  = rise | fall;
    assign meas    = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    // An edge on the timeout cycle masks the stall
    assign timeout = (cnt_q == TMO_LAST) && !edge_w;

    assign cnt_d = edge_w ? '0 : meas;
    assign ec_d  = edge_w ? ec_q + 16'd1 : ec_q;

    always_comb begin
        state_d = state_q;
        pv_d    = pv_q;
        st_d    = st_q;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (edge_w) state_d = ARMED;
            end
            ARMED: begin
                if (edge_w) begin
                    state_d = LOCKED;
                    cap     = 1'b1;
                    pv_d    = 1'b1;
                end else if (timeout) begin
                    state_d = STALL;
                    st_d    = 1'b1;
                    pv_d    = 1'b0;
                end
            end
            LOCKED: begin
                if (edge_w) begin
                    cap = 1'b1;
                end else if (timeout) begin
                    state_d = STALL;
                    st_d    = 1'b1;
                    pv_d    = 1'b0;
                end
            end
            STALL: begin
                if (edge_w) begin
                    state_d = ARMED;
                    st_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        hp_d = cap ? meas : hp_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hp_q    <= '0;
            pv_q    <= 1'b0;
            st_q    <= 1'b0;
            tr_q    <= 1'b0;
            tf_q    <= 1'b0;
            ec_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            pv_q    <= pv_d;
            st_q    <= st_d;
            tr_q    <= rise;
            tf_q    <= fall;
            ec_q    <= ec_d;
        end
    end

    assign mon.tick_rise    = tr_q;
    assign mon.tick_fall    = tf_q;
    assign mon.half_period  = hp_q;
    assign mon.period_valid = pv_q;
    assign mon.stalled      = st_q;
    assign mon.edge_count   = ec_q;

`ifdef SLOW_CLK_JITTER_CHECK_EN
    logic             jit_q, jit_d;
    logic [CNT_W-1:0] jdiff;

    // The first capture out of ARMED has no reference, so only LOCKED compares
    always_comb begin
        jdiff = (meas > hp_q) ? meas - hp_q : hp_q - meas;
        jit_d = jit_q;
        if (cap && state_q == LOCKED && jdiff > CNT_W'(JITTER_TOL))
            jit_d = 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) jit_q <= 1'b0;
        else        jit_q <= jit_d;
    end

    assign mon.jitter_err = jit_q;
`else
    assign mon.jitter_err = 1'b0;
`endif

endmodule

// File: doc/slow_clk_monitor.md
Name: slow_clk_monitor

Overview:
- Consumer-side companion to the team's clock dividers. Samples a slow divided clock (e.g. a 1 Hz-class toggle) that arrives as data in the fast clk domain.
- Synchronizes it and emits single-cycle rise/fall enable ticks, so downstream logic never clocks on the divided signal.
- Measures the half-period in clk cycles and flags a stalled source.

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth; legal values ≥2.
- CNT_W, 32, width of the half-period counter and measurement.
- TIMEOUT, 12_000_000, clk cycles without an edge before the source is declared stalled; legal range 2..2^CNT_W-1.

Ports:
- clk  in  1  fast system clock.
- n_rst  in  1  reset; asynchronous, active-low; clock clk.
- slow_clk  in  1  divided clock, asynchronous to clk.
- tick_rise  out  1  one-cycle pulse per synchronized rising edge.
- tick_fall  out  1  one-cycle pulse per synchronized falling edge.
- half_period  out  CNT_W  clk cycles between the last two edges.
- period_valid  out  1  half_period holds a full measurement.
- stalled  out  1  no edge for TIMEOUT cycles.
- edge_count  out  16  total edges seen; wraps modulo 2^16.

Behaviour:
- Reset: all synchronizer flops and the previous-sample flop = 0, cnt = 0, FSM = IDLE. All outputs = 0.
- Edge detect:
  - rise = sync & ~prev; fall = ~sync & prev.
  - Tick is high exactly 1 cycle.
  - Latency from a slow_clk change to the tick is SYNC_STAGES+1 clk edges.
- Counter cnt:
  - Set to 0 on an edge cycle; otherwise increments.
  - Saturates at 2^CNT_W-1; never wraps.
- Measurement: on an edge while in ARMED or LOCKED, half_period <= cnt+1, saturated at 2^CNT_W-1.
- FSM states:
  - IDLE: first edge -> ARMED. No capture, because the interval is partial.
  - ARMED: edge -> LOCKED with capture; period_valid <= 1.
  - LOCKED: edge -> stay in LOCKED and capture.
  - Timeout from ARMED or LOCKED: cnt == TIMEOUT-1 with no edge -> STALL, stalled <= 1, period_valid <= 0; half_period keeps its last value.
  - STALL: edge -> ARMED, stalled <= 0. No capture, because the interval is not meaningful.
  - IDLE never times out.
- Simultaneous edge and timeout in the same cycle: the edge wins, no stall.
- edge_count increments on every rise or fall, in every state.
- Mid-operation reset: immediate return to the reset values. The first post-reset edge is detected only if the synchronized level is 1, because prev resets to 0.
- A slow_clk pulse shorter than one clk period may be missed; this is not an error.

Optional Feature:
- Macro: SLOW_CLK_JITTER_CHECK_EN.
- Defined:
  - Adds parameter JITTER_TOL (default 2) and port jitter_err out 1.
  - In LOCKED, each new capture is compared with the previous half_period. If the absolute difference exceeds JITTER_TOL, jitter_err is set.
  - jitter_err is sticky until reset.
- Undefined: the port exists but is tied to 0, and no comparator logic is generated.

Decomposition:
- Package slow_clk_pkg:
  - typedef enum logic [1:0] mon_state_t {IDLE, ARMED, LOCKED, STALL}.
  - Default constants DEF_SYNC_STAGES, DEF_TIMEOUT, DEF_JITTER_TOL.
- One sub-module, sync_edge_detect: SYNC_STAGES synchronizer plus the prev flop. Outputs sync_level, rise, fall.

Test Plan:
- Reset mid-run: assert n_rst low while in LOCKED -> every output is 0 within the same cycle; after release, 2 edges are required before period_valid=1.
- Steady source: slow_clk toggles every 5 clk cycles -> first edge gives no valid; second edge gives half_period=5, period_valid=1; ticks alternate rise/fall, 1 cycle wide, each 3 cycles after the input change.
- Stall: TIMEOUT=20, source stops after lock -> stalled=1 and period_valid=0 exactly 20 cycles after the last edge; half_period unchanged. The next edge -> stalled=0, state ARMED; the following edge recaptures.
- Edge/timeout collision: TIMEOUT=20, edge lands on the cycle where cnt==19 -> stalled stays 0 and half_period=20.
- Counter wrap: 65537 edges -> edge_count=1.
- SLOW_CLK_JITTER_CHECK_EN: half-periods 10, 11, 14 with JITTER_TOL=2 -> jitter_err stays 0 after 11, is 1 after 14, and stays 1 until reset.
